pc_unit: RTL and testbench

Parametrised successor to the single-cycle Program_Counter. It holds the fetch PC and selects the next PC by priority from sequential step, branch/jump redirect, trap entry and trap return. It supports stall, misaligned-target fault detection, and cycle/retired-instruction counters. It sits between the next-PC logic and instruction memory in the single-cycle RISC-V core.

---
 rtl/core_pkg.sv | 18 +
 rtl/pc_counter.sv | 26 ++
 rtl/pc_unit.sv | 108 ++++++++++
 tb/tb_pc_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and helpers for the fetch-PC logic: state encoding, step sizes
// and the instruction-alignment mask.
package core_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } pc_state_t;

    localparam int STEP_32 = 4;
    localparam int STEP_16 = 2;

    // Low-order PC bits that must be zero for a legal target.
    function automatic logic [1:0] align_low_mask(input int ialign);
        return (ialign == 16) ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Free-running wrapping counter with enable; used for cycle and instret.
module pc_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) count_d = count_q + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: prioritised next-PC select, stall, misaligned-target
// fault capture, and cycle / retired-instruction counters.
//   state | meaning
//   RUN   | normal fetch, PC advances or is redirected
//   FAULT | misaligned redirect seen, PC frozen until trap_take
module pc_unit
    import core_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              IALIGN       = 32,
    parameter int              CNT_W        = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             is_compressed,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_take,
    input  logic [XLEN-1:0]  trap_vector,
    input  logic             mret,
    input  logic [XLEN-1:0]  epc,
    input  logic             retire,
    output logic [XLEN-1:0]  address,
    output logic [XLEN-1:0]  pc_plus,
    output logic             misaligned,
    output logic [XLEN-1:0]  bad_target,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    localparam logic [XLEN-1:0] MASK = {{(XLEN-2){1'b0}}, align_low_mask(IALIGN)};

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] bad_q, bad_d;
    logic [XLEN-1:0] step;
    logic            target_bad;
    logic            instret_en;

    assign step       = (IALIGN == 16 && is_compressed) ? XLEN'(STEP_16) : XLEN'(STEP_32);
    assign pc_plus    = addr_q + step;
    assign target_bad = |(redirect_target & MASK);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bad_d   = bad_q;
        unique case (state_q)
            RUN: begin
                if (trap_take) begin
                    addr_d = trap_vector & ~MASK;
                end else if (mret) begin
                    addr_d = epc & ~MASK;
                end else if (redirect_valid && !target_bad) begin
                    addr_d = redirect_target;
                end else if (redirect_valid) begin
                    bad_d   = redirect_target;
                    state_d = FAULT;
                end else if (!stall) begin
                    addr_d = pc_plus;
                end
            end
            FAULT: begin
                if (trap_take) begin
                    addr_d  = trap_vector & ~MASK;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            addr_q  <= RESET_VECTOR;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bad_q   <= bad_d;
        end
    end

    assign address    = addr_q;
    assign misaligned = (state_q == FAULT);
    assign bad_target = bad_q;

    // Retirement only counts in RUN and not on the cycle a trap is taken.
    assign instret_en = retire && (state_q == RUN) && !trap_take;

    pc_counter #(.W(CNT_W)) u_cycle (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .count (cycle_count)
    );

    pc_counter #(.W(CNT_W)) u_instret (
        .clk   (clk),
        .reset (reset),
        .en    (instret_en),
        .count (instret_count)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: one 32-bit-aligned and one compressed-capable instance.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, is_compressed, redirect_valid, trap_take, mret, retire;
    logic [31:0] redirect_target, trap_vector, epc;

    logic [31:0] addr32, plus32, bad32, addr16, plus16, bad16;
    logic        mis32, mis16;
    logic [63:0] cyc32, ins32, cyc16, ins16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_unit #(.IALIGN(32)) dut32 (
        .clk(clk), .reset(reset), .stall(stall), .is_compressed(is_compressed),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_take(trap_take), .trap_vector(trap_vector), .mret(mret), .epc(epc),
        .retire(retire), .address(addr32), .pc_plus(plus32), .misaligned(mis32),
        .bad_target(bad32), .cycle_count(cyc32), .instret_count(ins32)
    );

    pc_unit #(.IALIGN(16)) dut16 (
        .clk(clk), .reset(reset), .stall(stall), .is_compressed(is_compressed),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_take(trap_take), .trap_vector(trap_vector), .mret(mret), .epc(epc),
        .retire(retire), .address(addr16), .pc_plus(plus16), .misaligned(mis16),
        .bad_target(bad16), .cycle_count(cyc16), .instret_count(ins16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; is_compressed = 0; redirect_valid = 0; trap_take = 0;
        mret = 0; retire = 0;
        redirect_target = '0; trap_vector = '0; epc = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick(); tick();
        checks++;
        if (addr32 !== 32'h0 || mis32 !== 1'b0 || bad32 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: addr=%h mis=%b bad=%h want 0/0/0", addr32, mis32, bad32);
        end
        checks++;
        if (cyc32 !== 64'd0 || ins32 !== 64'd0) begin
            errors++;
            $display("FAIL reset_counters: cyc=%0d ins=%0d want 0/0", cyc32, ins32);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        reset = 0;
        retire = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = 32'(i * 4);
            checks++;
            if (addr32 !== exp) begin
                errors++;
                $display("FAIL seq_addr%0d: got %h want %h", i, addr32, exp);
            end
        end
        checks++;
        if (cyc32 !== 64'd3 || ins32 !== 64'd3) begin
            errors++;
            $display("FAIL seq_counts: cyc=%0d ins=%0d want 3/3", cyc32, ins32);
        end
        retire = 0;
    endtask

    task automatic test_stall();
        stall = 1;
        tick(); tick();
        checks++;
        if (addr32 !== 32'hC) begin
            errors++;
            $display("FAIL stall_hold: got %h want 0000000c", addr32);
        end
        stall = 0;
        tick();
        checks++;
        if (addr32 !== 32'h10) begin
            errors++;
            $display("FAIL stall_release: got %h want 00000010", addr32);
        end
    endtask

    task automatic test_redirect_wrap();
        stall = 1; redirect_valid = 1; redirect_target = 32'h40;
        tick();
        checks++;
        if (addr32 !== 32'h40) begin
            errors++;
            $display("FAIL redirect_over_stall: got %h want 00000040", addr32);
        end
        stall = 0; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 0;
        #1;
        checks++;
        if (addr32 !== 32'hFFFF_FFFC || plus32 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc_plus: addr=%h plus=%h want fffffffc/00000000", addr32, plus32);
        end
        tick();
        checks++;
        if (addr32 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: got %h want 00000000", addr32);
        end
    endtask

    task automatic test_fault();
        logic [63:0] ins_before;
        redirect_valid = 1; redirect_target = 32'h42;
        tick();
        checks++;
        if (mis32 !== 1'b1 || bad32 !== 32'h42 || addr32 !== 32'h0) begin
            errors++;
            $display("FAIL fault_entry: mis=%b bad=%h addr=%h want 1/00000042/00000000", mis32, bad32, addr32);
        end
        ins_before = ins32;
        retire = 1; redirect_target = 32'h80; mret = 1; epc = 32'h200;
        tick(); tick();
        checks++;
        if (addr32 !== 32'h0 || mis32 !== 1'b1 || ins32 !== ins_before) begin
            errors++;
            $display("FAIL fault_ignores: addr=%h mis=%b ins=%0d want 00000000/1/%0d", addr32, mis32, ins32, ins_before);
        end
        redirect_valid = 0; mret = 0;
        trap_take = 1; trap_vector = 32'h103;
        tick();
        checks++;
        if (addr32 !== 32'h100 || mis32 !== 1'b0 || bad32 !== 32'h42 || ins32 !== ins_before) begin
            errors++;
            $display("FAIL fault_exit: addr=%h mis=%b bad=%h ins=%0d want 00000100/0/00000042/%0d",
                     addr32, mis32, bad32, ins32, ins_before);
        end
        trap_take = 0; retire = 0;
    endtask

    task automatic test_priority();
        trap_take = 1; trap_vector = 32'h300; mret = 1; epc = 32'h400;
        redirect_valid = 1; redirect_target = 32'h500;
        tick();
        checks++;
        if (addr32 !== 32'h300) begin
            errors++;
            $display("FAIL prio_trap: got %h want 00000300", addr32);
        end
        mret = 0; trap_vector = 32'h310; redirect_target = 32'h502;
        tick();
        checks++;
        if (addr32 !== 32'h310 || mis32 !== 1'b0 || bad32 !== 32'h42) begin
            errors++;
            $display("FAIL prio_trap_vs_bad_redirect: addr=%h mis=%b bad=%h want 00000310/0/00000042", addr32, mis32, bad32);
        end
        trap_take = 0; mret = 1; epc = 32'h206; redirect_target = 32'h600;
        tick();
        checks++;
        if (addr32 !== 32'h204) begin
            errors++;
            $display("FAIL mret_align: got %h want 00000204", addr32);
        end
        idle();
    endtask

    task automatic test_ialign16();
        reset = 1;
        tick();
        reset = 0;
        is_compressed = 1;
        tick();
        checks++;
        if (addr16 !== 32'h2 || addr32 !== 32'h4) begin
            errors++;
            $display("FAIL compressed_step: a16=%h a32=%h want 00000002/00000004", addr16, addr32);
        end
        is_compressed = 0;
        redirect_valid = 1; redirect_target = 32'h42;
        tick();
        checks++;
        if (addr16 !== 32'h42 || mis16 !== 1'b0) begin
            errors++;
            $display("FAIL ialign16_accept: addr=%h mis=%b want 00000042/0", addr16, mis16);
        end
        redirect_target = 32'h41;
        tick();
        checks++;
        if (addr16 !== 32'h42 || mis16 !== 1'b1 || bad16 !== 32'h41) begin
            errors++;
            $display("FAIL ialign16_fault: addr=%h mis=%b bad=%h want 00000042/1/00000041", addr16, mis16, bad16);
        end
        redirect_valid = 0;
        trap_take = 1; trap_vector = 32'h103;
        tick();
        checks++;
        if (addr16 !== 32'h102 || mis16 !== 1'b0) begin
            errors++;
            $display("FAIL ialign16_trap_align: addr=%h mis=%b want 00000102/0", addr16, mis16);
        end
        idle();
    endtask

    task automatic test_async_reset();
        redirect_valid = 1; redirect_target = 32'h43;
        tick();
        redirect_valid = 0;
        checks++;
        if (mis32 !== 1'b1 || mis16 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_fault: mis32=%b mis16=%b want 1/1", mis32, mis16);
        end
        @(negedge clk);
        reset = 1;
        #1;
        checks++;
        if (addr32 !== 32'h0 || mis32 !== 1'b0 || bad32 !== 32'h0 || cyc32 !== 64'd0 || ins32 !== 64'd0) begin
            errors++;
            $display("FAIL async_reset: addr=%h mis=%b bad=%h cyc=%0d ins=%0d want all zero",
                     addr32, mis32, bad32, cyc32, ins32);
        end
        checks++;
        if (addr16 !== 32'h0 || mis16 !== 1'b0 || bad16 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset16: addr=%h mis=%b bad=%h want all zero", addr16, mis16, bad16);
        end
        tick();
        reset = 0;
        tick();
        checks++;
        if (addr32 !== 32'h4 || cyc32 !== 64'd1) begin
            errors++;
            $display("FAIL post_reset_run: addr=%h cyc=%0d want 00000004/1", addr32, cyc32);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wrap();
        test_fault();
        test_priority();
        test_ialign16();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
